// File: rtl/regfile_sequencer_if.sv
// Command / LOAD-stream / DUMP-stream bundle between a requester and regfile_sequencer.
// The sequencer takes the slave side; the requester (or a bench) takes the master side.
interface regfile_sequencer_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 32
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_count,
    output in_valid, in_data,
    output out_ready,
    input  cmd_ready, in_ready,
    input  out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_count,
    input  in_valid, in_data,
    input  out_ready,
    output cmd_ready, in_ready,
    output out_valid, out_data, out_addr, out_last
  );

endinterface

// File: rtl/regfile_sequencer.sv
// Block-command master for a 2**AW x DW register file: LOAD streams words in,
// DUMP streams registers out, CLEAR zeroes a range; addresses wrap modulo 2**AW.
module regfile_sequencer #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sequencer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       ra,
  input  logic [DW-1:0]       rd,
  output logic [AW-1:0]       wa,
  output logic [DW-1:0]       wd,
  output logic                we
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** AW);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_DUMP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DUMP  = 3'd2,
    S_CLEAR = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic [CW-1:0] count_clamped;

  // Next-state and datapath; done is registered so it is high exactly while in FIN.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    remaining_d   = remaining_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_addr_d    = out_addr_q;
    out_last_d    = out_last_q;
    done_d        = 1'b0;
    count_clamped = (bus.cmd_count > DEPTH) ? DEPTH : bus.cmd_count;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          ptr_d       = bus.cmd_base;
          remaining_d = count_clamped;
          if (count_clamped == '0) begin
            state_d = S_FIN;
          end else begin
            case (bus.cmd_op)
              OP_LOAD:  state_d = S_LOAD;
              OP_DUMP:  state_d = S_DUMP;
              OP_CLEAR: state_d = S_CLEAR;
              default:  state_d = S_FIN;
            endcase
          end
        end
      end

      S_LOAD: begin
        if (bus.in_valid) begin
          ptr_d       = ptr_q + AW'(1);
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) state_d = S_FIN;
        end
      end

      S_CLEAR: begin
        ptr_d       = ptr_q + AW'(1);
        remaining_d = remaining_q - CW'(1);
        if (remaining_q == CW'(1)) state_d = S_FIN;
      end

      S_DUMP: begin
        // Retire the presented word first; a fetch in the same cycle overrides out_valid.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = S_FIN;
          end
        end
        if ((!out_valid_q || bus.out_ready) && (remaining_q != '0)) begin
          out_data_d  = rd;
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == CW'(1));
          ptr_d       = ptr_q + AW'(1);
          remaining_d = remaining_q - CW'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  // Write port is gated by rst so an aborting reset edge never writes the file.
  assign ra = ptr_q;
  assign wa = ptr_q;
  assign wd = (state_q == S_LOAD) ? bus.in_data : '0;
  assign we = !rst && (((state_q == S_LOAD) && bus.in_valid) || (state_q == S_CLEAR));

endmodule
